// File: rtl/dcache_read_ctrl.sv
// Read controller for one load port of the write-through L1 data cache.
// Sequences tag lookup, hit return, miss request/refill, kills and collision replays.
module dcache_read_ctrl #(
  parameter int          INDEX_WIDTH  = 12,
  parameter int          OFFSET_WIDTH = 4,
  parameter int          TAG_WIDTH    = 44,
  parameter int          SET_ASSOC    = 8,
  parameter int          RD_TX_ID     = 1,
  parameter logic [63:0] CACHED_BASE  = 64'h8000_0000,
  parameter logic [63:0] CACHED_SIZE  = 64'h4000_0000,
  parameter logic [63:0] APPROX_BASE  = 64'h9000_0000,
  parameter logic [63:0] APPROX_SIZE  = 64'h1000_0000
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cache_en_i,
  input  logic                                data_req_i,
  input  logic [INDEX_WIDTH-1:0]              address_index_i,
  input  logic [TAG_WIDTH-1:0]                address_tag_i,
  input  logic                                tag_valid_i,
  input  logic                                kill_req_i,
  input  logic [1:0]                          data_size_i,
  output logic                                data_gnt_o,
  output logic                                data_rvalid_o,
  output logic [63:0]                         data_rdata_o,
  output logic                                miss_req_o,
  input  logic                                miss_ack_i,
  output logic                                miss_nc_o,
  output logic                                miss_we_o,
  output logic [63:0]                         miss_wdata_o,
  output logic [63:0]                         miss_paddr_o,
  output logic                                miss_approx_o,
  output logic [SET_ASSOC-1:0]                miss_vld_bits_o,
  output logic [2:0]                          miss_size_o,
  output logic [2:0]                          miss_id_o,
  input  logic                                miss_replay_i,
  input  logic                                miss_rtrn_vld_i,
  input  logic [63:0]                         miss_rtrn_data_i,
  input  logic                                wr_cl_vld_i,
  output logic                                rd_req_o,
  input  logic                                rd_ack_i,
  output logic                                rd_tag_only_o,
  output logic [TAG_WIDTH-1:0]                rd_tag_o,
  output logic [INDEX_WIDTH-OFFSET_WIDTH-1:0] rd_idx_o,
  output logic [OFFSET_WIDTH-1:0]             rd_off_o,
  output logic                                approx_o,
  input  logic [63:0]                         rd_data_i,
  input  logic [SET_ASSOC-1:0]                rd_vld_bits_i,
  input  logic [SET_ASSOC-1:0]                rd_hit_oh_i
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MISS_REQ,
    MISS_WAIT,
    KILL_MISS,
    REPLAY_REQ,
    REPLAY_READ
  } state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [1:0]             size_q;
  logic [SET_ASSOC-1:0]   vld_q;

  logic                   cap_req, cap_tag, cap_vld;
  logic [INDEX_WIDTH-1:0] lookup_idx;
  logic [TAG_WIDTH-1:0]   lookup_tag;
  logic [63:0]            paddr;
  logic                   cacheable, in_approx, hit;

  // The tag arrives live in the READ cycle; every later phase works off the stored copy.
  assign lookup_tag = (state_q == READ && tag_valid_i) ? address_tag_i : tag_q;
  assign lookup_idx = (state_q == IDLE) ? address_index_i : idx_q;
  assign paddr      = 64'({lookup_tag, lookup_idx});

  assign cacheable  = (paddr >= CACHED_BASE) && (paddr < CACHED_BASE + CACHED_SIZE);
  assign in_approx  = (paddr >= APPROX_BASE) && (paddr < APPROX_BASE + APPROX_SIZE);
  assign hit        = (|rd_hit_oh_i) && cache_en_i && cacheable;

  assign rd_tag_only_o   = 1'b0;
  assign rd_tag_o        = lookup_tag;
  assign rd_idx_o        = lookup_idx[INDEX_WIDTH-1:OFFSET_WIDTH];
  assign rd_off_o        = lookup_idx[OFFSET_WIDTH-1:0];
  assign approx_o        = in_approx;

  assign miss_we_o       = 1'b0;
  assign miss_wdata_o    = '0;
  assign miss_id_o       = 3'(RD_TX_ID);
  assign miss_paddr_o    = paddr;
  assign miss_approx_o   = in_approx;
  assign miss_vld_bits_o = vld_q;
  // Qualified by the request so the miss attributes stay quiet while no miss is pending.
  assign miss_nc_o       = miss_req_o & (~cache_en_i | ~cacheable);
  assign miss_size_o     = !miss_req_o ? 3'b000 :
                           miss_nc_o   ? {1'b0, size_q} : 3'b111;

  // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    data_rdata_o  = '0;
    miss_req_o    = 1'b0;
    rd_req_o      = 1'b0;
    cap_req       = 1'b0;
    cap_tag       = 1'b0;
    cap_vld       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (data_req_i) begin
          rd_req_o = 1'b1;
          if (rd_ack_i) begin
            data_gnt_o = 1'b1;
            cap_req    = 1'b1;
            state_d    = READ;
          end
        end
      end

      READ, REPLAY_READ: begin
        if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = IDLE;
        end else if (state_q == REPLAY_READ || tag_valid_i) begin
          cap_tag = (state_q == READ);
          cap_vld = 1'b1;
          if (wr_cl_vld_i) begin
            state_d = REPLAY_REQ;
          end else if (hit) begin
            data_rvalid_o = 1'b1;
            data_rdata_o  = rd_data_i;
            state_d       = IDLE;
          end else begin
            state_d = MISS_REQ;
          end
        end
      end

      MISS_REQ: begin
        miss_req_o = 1'b1;
        if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = miss_ack_i ? KILL_MISS : IDLE;
        end else if (miss_replay_i) begin
          state_d = REPLAY_REQ;
        end else if (miss_ack_i) begin
          state_d = MISS_WAIT;
        end
      end

      MISS_WAIT: begin
        if (miss_rtrn_vld_i) begin
          data_rvalid_o = 1'b1;
          data_rdata_o  = kill_req_i ? 64'h0 : miss_rtrn_data_i;
          state_d       = IDLE;
        end else if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = KILL_MISS;
        end
      end

      // The killed miss is still in flight; swallow its return silently.
      KILL_MISS: begin
        if (miss_rtrn_vld_i) state_d = IDLE;
      end

      REPLAY_REQ: begin
        rd_req_o = 1'b1;
        if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = IDLE;
        end else if (rd_ack_i) begin
          state_d = REPLAY_READ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
      size_q  <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cap_req) begin
        idx_q  <= address_index_i;
        size_q <= data_size_i;
      end
      if (cap_tag) tag_q <= address_tag_i;
      if (cap_vld) vld_q <= rd_vld_bits_i;
    end
  end

endmodule

// File: tb/tb_dcache_read_ctrl.sv
// Directed self-checking bench for dcache_read_ctrl: hit, miss, noncacheable,
// approx, collision replay, kill during miss, miss replay and reset mid-miss.
module tb_dcache_read_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cache_en_i;
  logic         data_req_i;
  logic [11:0]  address_index_i;
  logic [43:0]  address_tag_i;
  logic         tag_valid_i;
  logic         kill_req_i;
  logic [1:0]   data_size_i;
  logic         data_gnt_o;
  logic         data_rvalid_o;
  logic [63:0]  data_rdata_o;
  logic         miss_req_o;
  logic         miss_ack_i;
  logic         miss_nc_o;
  logic         miss_we_o;
  logic [63:0]  miss_wdata_o;
  logic [63:0]  miss_paddr_o;
  logic         miss_approx_o;
  logic [7:0]   miss_vld_bits_o;
  logic [2:0]   miss_size_o;
  logic [2:0]   miss_id_o;
  logic         miss_replay_i;
  logic         miss_rtrn_vld_i;
  logic [63:0]  miss_rtrn_data_i;
  logic         wr_cl_vld_i;
  logic         rd_req_o;
  logic         rd_ack_i;
  logic         rd_tag_only_o;
  logic [43:0]  rd_tag_o;
  logic [7:0]   rd_idx_o;
  logic [3:0]   rd_off_o;
  logic         approx_o;
  logic [63:0]  rd_data_i;
  logic [7:0]   rd_vld_bits_i;
  logic [7:0]   rd_hit_oh_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  dcache_read_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cache_en_i(cache_en_i), .data_req_i(data_req_i),
    .address_index_i(address_index_i), .address_tag_i(address_tag_i),
    .tag_valid_i(tag_valid_i), .kill_req_i(kill_req_i), .data_size_i(data_size_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .miss_req_o(miss_req_o), .miss_ack_i(miss_ack_i), .miss_nc_o(miss_nc_o),
    .miss_we_o(miss_we_o), .miss_wdata_o(miss_wdata_o), .miss_paddr_o(miss_paddr_o),
    .miss_approx_o(miss_approx_o), .miss_vld_bits_o(miss_vld_bits_o),
    .miss_size_o(miss_size_o), .miss_id_o(miss_id_o), .miss_replay_i(miss_replay_i),
    .miss_rtrn_vld_i(miss_rtrn_vld_i), .miss_rtrn_data_i(miss_rtrn_data_i),
    .wr_cl_vld_i(wr_cl_vld_i), .rd_req_o(rd_req_o), .rd_ack_i(rd_ack_i),
    .rd_tag_only_o(rd_tag_only_o), .rd_tag_o(rd_tag_o), .rd_idx_o(rd_idx_o),
    .rd_off_o(rd_off_o), .approx_o(approx_o), .rd_data_i(rd_data_i),
    .rd_vld_bits_i(rd_vld_bits_i), .rd_hit_oh_i(rd_hit_oh_i)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle after input changes, well before the next edge.
  task automatic settle();
    #1;
  endtask

  task automatic grant(input logic [43:0] tag, input logic [1:0] size);
    data_req_i = 1'b1; address_index_i = 12'h040; data_size_i = size; rd_ack_i = 1'b1;
    address_tag_i = tag;
    tick();
    data_req_i = 1'b0; rd_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; cache_en_i = 1'b1; data_req_i = 1'b0; address_index_i = '0;
    address_tag_i = '0; tag_valid_i = 1'b0; kill_req_i = 1'b0; data_size_i = '0;
    miss_ack_i = 1'b0; miss_replay_i = 1'b0; miss_rtrn_vld_i = 1'b0; miss_rtrn_data_i = '0;
    wr_cl_vld_i = 1'b0; rd_ack_i = 1'b0; rd_data_i = '0; rd_vld_bits_i = '0; rd_hit_oh_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    settle();
    check("reset_gnt", 64'(data_gnt_o), 64'h0);
    check("reset_rvalid", 64'(data_rvalid_o), 64'h0);
    check("reset_rd_req", 64'(rd_req_o), 64'h0);
    check("reset_miss_req", 64'(miss_req_o), 64'h0);
    check("reset_miss_nc", 64'(miss_nc_o), 64'h0);

    // Hit: grant, then tag next cycle returns data in that cycle.
    data_req_i = 1'b1; address_index_i = 12'h040; data_size_i = 2'd3; rd_ack_i = 1'b1;
    settle();
    check("hit_rd_req", 64'(rd_req_o), 64'h1);
    check("hit_gnt", 64'(data_gnt_o), 64'h1);
    check("hit_rd_idx", 64'(rd_idx_o), 64'h04);
    tick();
    data_req_i = 1'b0; rd_ack_i = 1'b0;
    tag_valid_i = 1'b1; address_tag_i = 44'h80000; rd_hit_oh_i = 8'h01; rd_data_i = 64'hDEAD;
    settle();
    check("hit_rvalid", 64'(data_rvalid_o), 64'h1);
    check("hit_rdata", data_rdata_o, 64'hDEAD);
    check("hit_rd_tag", 64'(rd_tag_o), 64'h80000);
    check("hit_no_gnt_in_read", 64'(data_gnt_o), 64'h0);
    tick();
    tag_valid_i = 1'b0; rd_hit_oh_i = '0;
    settle();
    check("hit_single_pulse", 64'(data_rvalid_o), 64'h0);

    // Cacheable miss with held miss_req, then refill.
    grant(44'h0, 2'd3);
    tag_valid_i = 1'b1; address_tag_i = 44'h80000; rd_vld_bits_i = 8'hA5;
    settle();
    check("miss_no_rvalid", 64'(data_rvalid_o), 64'h0);
    tick();
    tag_valid_i = 1'b0; address_tag_i = 44'h0; rd_vld_bits_i = 8'h00;
    settle();
    check("miss_req", 64'(miss_req_o), 64'h1);
    check("miss_paddr", miss_paddr_o, 64'h8000_0040);
    check("miss_size", 64'(miss_size_o), 64'h7);
    check("miss_nc", 64'(miss_nc_o), 64'h0);
    check("miss_vld_bits", 64'(miss_vld_bits_o), 64'hA5);
    check("miss_approx", 64'(miss_approx_o), 64'h0);
    tick();
    settle();
    check("miss_req_held", 64'(miss_req_o), 64'h1);
    miss_ack_i = 1'b1;
    tick();
    miss_ack_i = 1'b0;
    settle();
    check("miss_wait_no_req", 64'(miss_req_o), 64'h0);
    check("miss_wait_no_rvalid", 64'(data_rvalid_o), 64'h0);
    miss_rtrn_vld_i = 1'b1; miss_rtrn_data_i = 64'hBEEF;
    settle();
    check("miss_rtrn_rvalid", 64'(data_rvalid_o), 64'h1);
    check("miss_rtrn_rdata", data_rdata_o, 64'hBEEF);
    tick();
    miss_rtrn_vld_i = 1'b0;

    // Noncacheable: paddr 0x1000_0040 even with a hit vector.
    grant(44'h0, 2'd2);
    tag_valid_i = 1'b1; address_tag_i = 44'h10000; rd_hit_oh_i = 8'h01;
    settle();
    check("nc_no_hit", 64'(data_rvalid_o), 64'h0);
    tick();
    tag_valid_i = 1'b0; rd_hit_oh_i = '0;
    settle();
    check("nc_miss_nc", 64'(miss_nc_o), 64'h1);
    check("nc_miss_size", 64'(miss_size_o), 64'h2);
    check("nc_paddr", miss_paddr_o, 64'h1000_0040);
    miss_ack_i = 1'b1;
    tick();
    miss_ack_i = 1'b0; miss_rtrn_vld_i = 1'b1; miss_rtrn_data_i = 64'h55;
    tick();
    miss_rtrn_vld_i = 1'b0;

    // Approx region (still cacheable) hit.
    grant(44'h0, 2'd3);
    tag_valid_i = 1'b1; address_tag_i = 44'h90000; rd_hit_oh_i = 8'h02; rd_data_i = 64'h77;
    settle();
    check("approx_flag", 64'(approx_o), 64'h1);
    check("approx_hit_rdata", data_rdata_o, 64'h77);
    tick();
    tag_valid_i = 1'b0; rd_hit_oh_i = '0;

    // Collision: line write during lookup forces replay lookup.
    grant(44'h0, 2'd3);
    tag_valid_i = 1'b1; address_tag_i = 44'h80000; rd_hit_oh_i = 8'h01; wr_cl_vld_i = 1'b1;
    rd_data_i = 64'h1111;
    settle();
    check("coll_no_rvalid", 64'(data_rvalid_o), 64'h0);
    tick();
    tag_valid_i = 1'b0; wr_cl_vld_i = 1'b0; address_tag_i = 44'h0; data_req_i = 1'b1;
    settle();
    check("coll_rd_req", 64'(rd_req_o), 64'h1);
    check("coll_rd_tag", 64'(rd_tag_o), 64'h80000);
    check("coll_no_gnt", 64'(data_gnt_o), 64'h0);
    tick();
    data_req_i = 1'b0;
    settle();
    check("coll_rd_req_held", 64'(rd_req_o), 64'h1);
    rd_ack_i = 1'b1;
    tick();
    rd_ack_i = 1'b0; rd_data_i = 64'h1234;
    settle();
    check("coll_replay_rvalid", 64'(data_rvalid_o), 64'h1);
    check("coll_replay_rdata", data_rdata_o, 64'h1234);
    tick();
    rd_hit_oh_i = '0;

    // Kill during MISS_WAIT: immediate response, later return swallowed.
    grant(44'h0, 2'd3);
    tag_valid_i = 1'b1; address_tag_i = 44'h80000;
    tick();
    tag_valid_i = 1'b0; miss_ack_i = 1'b1;
    tick();
    miss_ack_i = 1'b0; kill_req_i = 1'b1;
    settle();
    check("kill_rvalid", 64'(data_rvalid_o), 64'h1);
    tick();
    kill_req_i = 1'b0; data_req_i = 1'b1; rd_ack_i = 1'b1;
    settle();
    check("killmiss_no_gnt", 64'(data_gnt_o), 64'h0);
    data_req_i = 1'b0; rd_ack_i = 1'b0; miss_rtrn_vld_i = 1'b1; miss_rtrn_data_i = 64'h99;
    settle();
    check("killmiss_no_rvalid", 64'(data_rvalid_o), 64'h0);
    tick();
    miss_rtrn_vld_i = 1'b0; data_req_i = 1'b1; rd_ack_i = 1'b1;
    settle();
    check("killmiss_back_idle", 64'(data_gnt_o), 64'h1);
    tick();
    data_req_i = 1'b0; rd_ack_i = 1'b0; kill_req_i = 1'b1;
    settle();
    check("kill_in_read_rvalid", 64'(data_rvalid_o), 64'h1);
    tick();
    kill_req_i = 1'b0;

    // Miss replay: rejected miss re-runs the lookup, then requests again.
    grant(44'h0, 2'd3);
    tag_valid_i = 1'b1; address_tag_i = 44'h80000;
    tick();
    tag_valid_i = 1'b0; miss_replay_i = 1'b1;
    settle();
    check("replay_miss_req", 64'(miss_req_o), 64'h1);
    tick();
    miss_replay_i = 1'b0;
    settle();
    check("replay_rd_req", 64'(rd_req_o), 64'h1);
    check("replay_miss_req_drop", 64'(miss_req_o), 64'h0);
    rd_ack_i = 1'b1;
    tick();
    rd_ack_i = 1'b0;
    settle();
    check("replay_read_miss", 64'(data_rvalid_o), 64'h0);
    tick();
    settle();
    check("replay_miss_req_again", 64'(miss_req_o), 64'h1);
    check("replay_paddr", miss_paddr_o, 64'h8000_0040);

    // Reset mid-miss: back to idle, no response.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
    check("rst_mid_miss_req", 64'(miss_req_o), 64'h0);
    check("rst_mid_miss_rvalid", 64'(data_rvalid_o), 64'h0);
    data_req_i = 1'b1; rd_ack_i = 1'b1;
    settle();
    check("rst_mid_miss_idle", 64'(data_gnt_o), 64'h1);
    data_req_i = 1'b0; rd_ack_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_read_ctrl.md
# dcache_read_ctrl

Read controller for one load port of the write-through L1 data cache, between a core load requester (LSU or PTW) and the shared cache-memory arbiter and miss unit. It accepts a request with its index, performs the tag lookup, and returns data on a hit. On a miss it issues a miss request and returns the refill data. It also handles kills, refill/readout collisions and replays.

## Interface
Parameters:
- INDEX_WIDTH, 12, untranslated address index bits (index + offset)
- OFFSET_WIDTH, 4, byte offset within cacheline
- TAG_WIDTH, 44, physical tag bits
- SET_ASSOC, 8, ways
- RD_TX_ID, 1, transaction id on misses
- CACHED_BASE / CACHED_SIZE, 64'h8000_0000 / 64'h4000_0000, cacheable physical region
- APPROX_BASE / APPROX_SIZE, 64'h9000_0000 / 64'h1000_0000, approximate-storage region

Ports (paddr = {tag, index}, zero-extended to 64):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cache_en_i  in  1  cache enable from miss unit
- data_req_i  in  1  core read request
- address_index_i  in  INDEX_WIDTH  index+offset, valid with data_req_i
- address_tag_i  in  TAG_WIDTH  tag, valid with tag_valid_i
- tag_valid_i  in  1  tag presented (cycle after grant or later)
- kill_req_i  in  1  abort outstanding request
- data_size_i  in  2  log2 bytes
- data_gnt_o  out  1  request accepted
- data_rvalid_o  out  1  response valid (also on kill)
- data_rdata_o  out  64  response data
- miss_req_o / miss_ack_i  out/in  1  miss handshake
- miss_nc_o  out  1  noncacheable miss
- miss_we_o  out  1  constant 0
- miss_wdata_o  out  64  constant 0
- miss_paddr_o  out  64  miss physical address
- miss_approx_o  out  1  paddr in approx region
- miss_vld_bits_o  out  SET_ASSOC  valid bits captured at lookup
- miss_size_o  out  3  3'b111 cacheable, {1'b0,data_size} nc
- miss_id_o  out  3  RD_TX_ID
- miss_replay_i  in  1  miss unit rejects, replay lookup
- miss_rtrn_vld_i  in  1  miss completed
- miss_rtrn_data_i  in  64  returned word
- wr_cl_vld_i  in  1  cacheline write active (collision)
- rd_req_o / rd_ack_i  out/in  1  memory read port handshake
- rd_tag_only_o  out  1  tag-only lookup
- rd_tag_o  out  TAG_WIDTH; rd_idx_o  out  INDEX_WIDTH-OFFSET_WIDTH; rd_off_o  out  OFFSET_WIDTH
- approx_o  out  1  lookup address in approx region
- rd_data_i  in  64; rd_vld_bits_i  in  SET_ASSOC; rd_hit_oh_i  in  SET_ASSOC

## Operation
- States: IDLE, READ, MISS_REQ, MISS_WAIT, KILL_MISS, REPLAY_REQ, REPLAY_READ.
- IDLE: on data_req_i, rd_req_o=1, rd_tag_only_o=0, idx/off from address_index_i. On rd_ack_i, data_gnt_o=1, capture index and size, go to READ.
- READ: kill_req_i → data_rvalid_o=1, IDLE (kill has priority). Else on tag_valid_i: capture tag and rd_vld_bits_i.
  - hit = |rd_hit_oh_i & cache_en_i & cacheable(paddr).
  - wr_cl_vld_i → REPLAY_REQ.
  - hit → data_rvalid_o=1, data_rdata_o=rd_data_i, IDLE.
  - else → MISS_REQ.
- MISS_REQ: miss_req_o=1.
  - kill → rvalid=1; if miss_ack_i then KILL_MISS else IDLE.
  - miss_replay_i → REPLAY_REQ.
  - miss_ack_i → MISS_WAIT.
- MISS_WAIT: miss_rtrn_vld_i → rvalid=1, data=miss_rtrn_data_i, IDLE. Kill without rtrn → rvalid=1, KILL_MISS. Kill with rtrn → rvalid=1, IDLE.
- KILL_MISS: no response; miss_rtrn_vld_i → IDLE.
- REPLAY_REQ: rd_req_o=1, stored address, rd_tag_only_o=0. Kill → rvalid, IDLE. rd_ack_i → REPLAY_READ.
- REPLAY_READ: same decision as READ using stored tag, no tag_valid_i needed. Kill → rvalid, IDLE.
- miss_nc_o = ~cache_en_i | ~cacheable(paddr).
- approx_o / miss_approx_o = APPROX_BASE <= paddr < APPROX_BASE+APPROX_SIZE.
- rd_tag_o = address_tag_i in READ when tag_valid_i, else stored tag.

## Timing
- Reset: state IDLE; all outputs 0; stored regs 0.
- All outputs are combinational from state and inputs; state and capture regs update on the posedge.
- Hit latency: grant cycle + tag_valid cycle; rvalid is asserted in the tag_valid cycle.
- Exactly one data_rvalid_o pulse per granted request, including killed ones.
- No grant outside IDLE.
- rd_req_o is held until rd_ack_i.
- miss_req_o is held until miss_ack_i or miss_replay_i.
- Reset mid-miss → IDLE; no response.

## Test plan
- Hit: grant idx 0x040, tag 0x80000 the next cycle, hit_oh=0x01, rd_data=0xDEAD → rvalid with 0xDEAD one cycle after gnt.
- Miss: hit_oh=0 → miss_req with paddr 0x80000040, size 3'b111, nc=0. Then ack, rtrn 0xBEEF → rvalid with 0xBEEF.
- Noncacheable: tag maps to 0x1000_0040, size 2 → miss_nc=1, miss_size=3'b010.
- Collision: wr_cl_vld_i during tag_valid → REPLAY_REQ, rd_req re-issued, hit → rvalid.
- Kill in MISS_WAIT → immediate rvalid. Later miss_rtrn_vld causes no second rvalid; return to IDLE.
- Replay: miss_replay_i in MISS_REQ → replay lookup, then miss_req reasserted.
